// File: rtl/eth_pkg.sv
// ============================================================================
// Module      : eth_pkg
// Description : Shared types and constants for the RMII dibit datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_pkg;

    // One RMII transfer unit: two bits per clock.
    typedef logic [1:0] dibit_t;

    // A byte is always exactly four dibits on RMII; this value is fixed.
    localparam int DIBITS_PER_BYTE = 4;
    localparam int BYTE_W          = 8;

    // Width of the input-side dibit position counter (0..3).
    localparam int COLLECT_CNT_W   = $clog2(DIBITS_PER_BYTE);

    // Width of the output-side remaining-dibit counter (0..4).
    localparam int EMIT_CNT_W      = $clog2(DIBITS_PER_BYTE + 1);

    // Byte position of the final dibit of a byte, in collector counter width.
    localparam logic [COLLECT_CNT_W-1:0] LAST_DIBIT_IDX =
        COLLECT_CNT_W'(DIBITS_PER_BYTE - 1);

    // Number of dibits loaded into the serializer per byte.
    localparam logic [EMIT_CNT_W-1:0] EMIT_LOAD_CNT =
        EMIT_CNT_W'(DIBITS_PER_BYTE);

    // Assemble the final byte from the three dibits already held and the
    // dibit arriving now, which is always the most significant one.
    function automatic logic [BYTE_W-1:0] complete_byte(
        input logic [BYTE_W-1:0] partial,
        input dibit_t            last_dibit
    );
        complete_byte = {last_dibit, partial[BYTE_W-3:0]};
    endfunction

endpackage : eth_pkg

`default_nettype wire

// File: rtl/dibit_serializer.sv
// ============================================================================
// Module      : dibit_serializer
// Description : Parallel-load byte register that shifts its contents out
//               MSB-dibit-first, one dibit per clock, with a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dibit_serializer
    import eth_pkg::*;
(
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              load,
    input  logic [BYTE_W-1:0] load_data,
    output logic              out_valid,
    output dibit_t            out_dibit
);

    logic [BYTE_W-1:0]     shreg_q, shreg_d;
    logic [EMIT_CNT_W-1:0] remain_q, remain_d;
    logic                  valid_q, valid_d;

    // Next-state: a new byte always wins over an in-progress shift, so a load
    // landing on the last output dibit gives a gapless hand-over. Shifting in
    // zeros guarantees the register drains to 0 when emission finishes, which
    // keeps the output dibit at 0 whenever valid is low.
    always_comb begin
        shreg_d  = shreg_q;
        remain_d = remain_q;
        valid_d  = valid_q;
        if (load) begin
            shreg_d  = load_data;
            remain_d = EMIT_LOAD_CNT;
            valid_d  = 1'b1;
        end else if (remain_q != '0) begin
            shreg_d  = {shreg_q[BYTE_W-3:0], 2'b00};
            remain_d = remain_q - EMIT_CNT_W'(1);
            valid_d  = (remain_q != EMIT_CNT_W'(1));
        end
    end

    // State registers; reset drops any byte mid-emission immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q  <= '0;
            remain_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            remain_q <= remain_d;
            valid_q  <= valid_d;
        end
    end

    // Outputs come straight from flops; the top dibit of the shift register is
    // the one currently on the wire.
    assign out_valid = valid_q;
    assign out_dibit = shreg_q[BYTE_W-1 -: 2];

endmodule : dibit_serializer

`default_nettype wire

// File: rtl/bit_order.sv
// ============================================================================
// Module      : bit_order
// Description : RMII dibit re-orderer. Collects LSB-dibit-first bytes and
//               re-emits each complete byte MSB-dibit-first. Partial bytes at
//               frame end are silently discarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_order
    import eth_pkg::*;
(
    input  logic   clk,
    input  logic   rst,      // asynchronous, active-low
    input  logic   axiiv,
    input  dibit_t axiid,
    output logic   axiov,
    output dibit_t axiod
);

    logic [COLLECT_CNT_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0]        byte_q, byte_d;
    logic                     load;
    logic [BYTE_W-1:0]        load_data;

    // Collector: place each valid dibit at its byte position; on the fourth
    // dibit hand the finished byte to the serializer and restart at position
    // 0 with no idle cycle. A low valid ends the frame and throws away
    // whatever partial byte was being built.
    always_comb begin
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        load      = 1'b0;
        load_data = complete_byte(byte_q, axiid);
        if (axiiv) begin
            if (cnt_q == LAST_DIBIT_IDX) begin
                load   = 1'b1;
                cnt_d  = '0;
                byte_d = '0;
            end else begin
                byte_d[{cnt_q, 1'b0} +: 2] = axiid;
                cnt_d = cnt_q + COLLECT_CNT_W'(1);
            end
        end else begin
            cnt_d  = '0;
            byte_d = '0;
        end
    end

    // Collector state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            byte_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            byte_q <= byte_d;
        end
    end

    // One output buffer is enough: a new byte can only complete four cycles
    // after the previous one, exactly when that emission ends.
    dibit_serializer u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .out_valid (axiov),
        .out_dibit (axiod)
    );

endmodule : bit_order

`default_nettype wire

// File: tb/tb_bit_order.sv
// ============================================================================
// Module      : tb_bit_order
// Description : Self-checking bench for bit_order with directed scenarios and
//               randomized frames against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_order;

    logic       clk;
    logic       rst;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;

    int checks = 0;
    int errors = 0;

    // Reference model: dibits of the byte being gathered, and the dibits
    // still waiting to appear on the output, in wire order.
    logic [1:0] partial_q[$];
    logic [1:0] pending_q[$];

    bit_order dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bench cycle: at the falling edge report what the output should be
    // right now, then present the next input and update the model with it.
    task automatic tick(input logic v, input logic [1:0] d,
                        output logic exp_v, output logic [1:0] exp_d);
        @(negedge clk);
        if (pending_q.size() > 0) begin
            exp_v = 1'b1;
            exp_d = pending_q.pop_front();
        end else begin
            exp_v = 1'b0;
            exp_d = 2'b00;
        end
        axiiv = v;
        axiid = d;
        if (v) begin
            partial_q.push_back(d);
            if (partial_q.size() == 4) begin
                for (int k = 3; k >= 0; k--) pending_q.push_back(partial_q[k]);
                partial_q.delete();
            end
        end else begin
            partial_q.delete();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (axiov !== 1'b0 || axiod !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: axiov=%b axiod=%b, want 0/00", axiov, axiod);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Run a dibit list (valid when bit 2 set) then idle until drained.
    task automatic run_list(input string name, input logic [2:0] seq[$]);
        logic ev;
        logic [1:0] ed;
        for (int i = 0; i < seq.size() + 6; i++) begin
            if (i < seq.size()) tick(seq[i][2], seq[i][1:0], ev, ed);
            else                tick(1'b0, 2'b00, ev, ed);
            checks++;
            if (axiov !== ev || axiod !== ed) begin
                errors++;
                $display("FAIL %s cyc%0d: axiov=%b axiod=%b, want %b/%b",
                         name, i, axiov, axiod, ev, ed);
            end
        end
    endtask

    task automatic test_partial_drop();
        run_list("partial_drop", '{3'b110, 3'b110});
    endtask

    task automatic test_single_byte();
        run_list("single_byte", '{3'b110, 3'b110, 3'b111, 3'b111});
    endtask

    task automatic test_trailing_drop();
        run_list("trailing_drop", '{3'b110, 3'b110, 3'b111, 3'b111, 3'b101, 3'b101});
    endtask

    task automatic test_back_to_back();
        run_list("back_to_back", '{3'b110, 3'b110, 3'b111, 3'b111,
                                   3'b101, 3'b101, 3'b111, 3'b111});
    endtask

    task automatic test_mixed_bytes();
        run_list("mixed_bytes", '{3'b100, 3'b101, 3'b110, 3'b111, 3'b111,
                                  3'b110, 3'b101, 3'b110, 3'b101});
    endtask

    task automatic test_reset_mid();
        logic ev;
        logic [1:0] ed;
        logic [1:0] second;
        // Byte 8'h2D: dibits 01,11,10,00 in, 00,10,11,01 out.
        tick(1'b1, 2'b01, ev, ed);
        tick(1'b1, 2'b11, ev, ed);
        tick(1'b1, 2'b10, ev, ed);
        tick(1'b1, 2'b00, ev, ed);
        tick(1'b0, 2'b00, ev, ed);
        checks++;
        if (axiov !== ev || axiod !== ed) begin
            errors++;
            $display("FAIL rst_mid_first: axiov=%b axiod=%b, want %b/%b", axiov, axiod, ev, ed);
        end
        @(posedge clk);
        #1;
        second = pending_q[0];
        checks++;
        if (axiov !== 1'b1 || axiod !== second) begin
            errors++;
            $display("FAIL rst_mid_second: axiov=%b axiod=%b, want 1/%b", axiov, axiod, second);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (axiov !== 1'b0 || axiod !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_async: axiov=%b axiod=%b, want 0/00", axiov, axiod);
        end
        pending_q.delete();
        partial_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (axiov !== 1'b0 || axiod !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_hold: axiov=%b axiod=%b, want 0/00", axiov, axiod);
        end
        @(negedge clk);
        rst = 1'b1;
        run_list("after_reset", '{3'b100, 3'b101, 3'b110, 3'b111});
    endtask

    task automatic test_random();
        logic ev;
        logic [1:0] ed;
        for (int i = 0; i < 400; i++) begin
            logic v;
            v = ($urandom_range(0, 7) != 0);
            tick(v, 2'($urandom_range(0, 3)), ev, ed);
            checks++;
            if (axiov !== ev || axiod !== ed) begin
                errors++;
                $display("FAIL random cyc%0d: axiov=%b axiod=%b, want %b/%b",
                         i, axiov, axiod, ev, ed);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 2'b00, ev, ed);
            checks++;
            if (axiov !== ev || axiod !== ed) begin
                errors++;
                $display("FAIL random_drain cyc%0d: axiov=%b axiod=%b, want %b/%b",
                         i, axiov, axiod, ev, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_partial_drop();
        test_single_byte();
        test_trailing_drop();
        test_back_to_back();
        test_mixed_bytes();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bit_order

`default_nettype wire
